// File: rtl/pokemon_pkg.sv
// pokemon_pkg: requester ids, ROM geometry and requester-id type shared by the graphics ROM arbiter
package pokemon_pkg;
  localparam int REQ_PIXEL = 0;
  localparam int REQ_SPRITE = 1;
  localparam int REQ_TEXT = 2;
  localparam int ROM_ADDR_W = 16;
  localparam int ROM_DATA_W = 8;
  localparam int ROM_N_REQ = 3;
  typedef logic [$clog2(ROM_N_REQ)-1:0] rom_req_id_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker (mask, start -> one-hot onehot and index idx of first set mask bit at or after start)
module rr_pick #(
  parameter int N = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);
  logic [2*N-1:0] rot;
  always_comb begin
    rot = {mask, mask} >> start;
    onehot = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (rot[k]) begin
        idx = IW'((int'(start) + k) % N);
        onehot = N'(1) << idx;
      end
  end
endmodule

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: one graphics-ROM read port shared by req/addr requesters (pixel priority in display, else round-robin); gnt comb, rom_addr/rom_rd issue, tagged rvalid/rdata RD_LAT+2 cycles after grant
module rom_port_arbiter
  import pokemon_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    display_active,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]       rdata,
  output logic [ADDR_W-1:0]       rom_addr,
  output logic                    rom_rd,
  input  logic [DATA_W-1:0]       rom_q
);
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  logic [IW-1:0] rr_last, rr_start, rr_idx, gnt_idx;
  logic [N_REQ-1:0] rr_mask, rr_gnt;
  logic pri;
  logic tag_v [RD_LAT+1];
  logic [IW-1:0] tag_i [RD_LAT+1];
  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .mask(rr_mask),
    .start(rr_start),
    .onehot(rr_gnt),
    .idx(rr_idx)
  );
  always_comb begin
    pri = display_active && req[REQ_PIXEL];
    rr_mask = display_active ? req & ~(N_REQ'(1) << REQ_PIXEL) : req;
    rr_start = rr_last == IW'(N_REQ - 1) ? '0 : rr_last + IW'(1);
    gnt = Reset ? '0 : pri ? N_REQ'(1) << REQ_PIXEL : rr_gnt;
    gnt_idx = pri ? IW'(REQ_PIXEL) : rr_idx;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rr_last <= IW'(N_REQ - 1);
      rom_addr <= '0;
      rom_rd <= 1'b0;
      rvalid <= '0;
      rdata <= '0;
      for (int s = 0; s <= RD_LAT; s++) begin
        tag_v[s] <= 1'b0;
        tag_i[s] <= '0;
      end
    end else begin
      if (|rr_gnt && !pri) rr_last <= rr_idx;
      if (|gnt) rom_addr <= addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
      rom_rd <= |gnt;
      tag_v[0] <= |gnt;
      tag_i[0] <= gnt_idx;
      for (int s = 1; s <= RD_LAT; s++) begin
        tag_v[s] <= tag_v[s-1];
        tag_i[s] <= tag_i[s-1];
      end
      rvalid <= tag_v[RD_LAT] ? N_REQ'(1) << tag_i[RD_LAT] : '0;
      if (tag_v[RD_LAT]) rdata <= rom_q;
    end
  end
endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: random and directed stimulus on RD_LAT=1 and RD_LAT=3 arbiters checked against a cycle-indexed reference model
module tb_rom_port_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, display_active;
  logic [2:0] req;
  logic [47:0] addr;
  logic [2:0] g1, g3, rv1, rv3;
  logic [7:0] rd1, rd3, q1, q3a, q3b, q3c;
  logic [15:0] ra1, ra3;
  logic rr1, rr3;
  rom_port_arbiter #(.N_REQ(3), .ADDR_W(16), .DATA_W(8), .RD_LAT(1)) u1 (
    .Clk(clk), .Reset(reset), .display_active(display_active), .req(req), .addr(addr),
    .gnt(g1), .rvalid(rv1), .rdata(rd1), .rom_addr(ra1), .rom_rd(rr1), .rom_q(q1)
  );
  rom_port_arbiter #(.N_REQ(3), .ADDR_W(16), .DATA_W(8), .RD_LAT(3)) u3 (
    .Clk(clk), .Reset(reset), .display_active(display_active), .req(req), .addr(addr),
    .gnt(g3), .rvalid(rv3), .rdata(rd3), .rom_addr(ra3), .rom_rd(rr3), .rom_q(q3c)
  );
  function automatic logic [7:0] rom_f(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h78;
  endfunction
  always @(posedge clk) begin
    q1 <= rom_f(ra1);
    q3a <= rom_f(ra3);
    q3b <= q3a;
    q3c <= q3b;
  end
  int n_chk = 0, n_pass = 0, n = 0, m_rr = 2, pg = -1;
  logic [2:0] ev1 [0:4095];
  logic [2:0] ev3 [0:4095];
  logic [7:0] ed1 [0:4095];
  logic [7:0] ed3 [0:4095];
  logic rst_h [0:4095];
  logic [7:0] m_rd1 = 8'h00, m_rd3 = 8'h00;
  logic [15:0] m_addr = 16'h0000, pa = 16'h0000;
  logic prst = 1'b1, fix = 1'b0;
  logic [2:0] last_req = 3'b000, last_gnt = 3'b000;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, n, obs, exp);
  endtask
  task automatic cyc(input logic [2:0] r, input logic d, input logic rs);
    int eg;
    logic [2:0] eo;
    @(posedge clk);
    #1;
    n++;
    for (int i = 0; i < 3; i++)
      if (!fix && !(last_req[i] && !last_gnt[i])) addr[i*16 +: 16] = 16'($urandom);
    req = r;
    display_active = d;
    reset = rs;
    @(negedge clk);
    if (rst_h[n-1]) begin
      m_rd1 = 8'h00;
      m_rd3 = 8'h00;
    end else begin
      if (ev1[n] != 3'b000) m_rd1 = ed1[n];
      if (ev3[n] != 3'b000) m_rd3 = ed3[n];
    end
    chk("rvalid_lat1", 32'(rv1), 32'(ev1[n]));
    chk("rdata_lat1", 32'(rd1), 32'(m_rd1));
    chk("rvalid_lat3", 32'(rv3), 32'(ev3[n]));
    chk("rdata_lat3", 32'(rd3), 32'(m_rd3));
    if (prst) m_addr = 16'h0000;
    else if (pg >= 0) m_addr = pa;
    chk("rom_rd_lat1", 32'(rr1), 32'(!prst && pg >= 0));
    chk("rom_rd_lat3", 32'(rr3), 32'(!prst && pg >= 0));
    chk("rom_addr_lat1", 32'(ra1), 32'(m_addr));
    chk("rom_addr_lat3", 32'(ra3), 32'(m_addr));
    eg = -1;
    if (!rs) begin
      if (d && r[0]) eg = 0;
      else
        for (int k = 1; k <= 3; k++)
          if (eg < 0 && r[(m_rr + k) % 3] && !(d && (m_rr + k) % 3 == 0)) eg = (m_rr + k) % 3;
    end
    eo = eg < 0 ? 3'b000 : 3'(1 << eg);
    chk("gnt_lat1", 32'(g1), 32'(eo));
    chk("gnt_lat3", 32'(g3), 32'(eo));
    if (rs) begin
      m_rr = 2;
      rst_h[n] = 1'b1;
      for (int k = 1; k <= 5; k++) begin
        ev1[n+k] = k <= 3 ? 3'b000 : ev1[n+k];
        ev3[n+k] = 3'b000;
      end
    end else if (eg >= 0) begin
      if (!(d && eg == 0)) m_rr = eg;
      ev1[n+3] = eo;
      ed1[n+3] = rom_f(addr[eg*16 +: 16]);
      ev3[n+5] = eo;
      ed3[n+5] = rom_f(addr[eg*16 +: 16]);
      pa = addr[eg*16 +: 16];
    end
    pg = eg;
    prst = rs;
    last_req = r;
    last_gnt = eo;
  endtask
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(3'b000, 1'b0, 1'b0);
  endtask
  initial begin
    logic [2:0] r;
    logic d;
    for (int i = 0; i < 4096; i++) begin
      ev1[i] = 3'b000;
      ev3[i] = 3'b000;
      ed1[i] = 8'h00;
      ed3[i] = 8'h00;
      rst_h[i] = 1'b0;
    end
    rst_h[0] = 1'b1;
    reset = 1'b1;
    display_active = 1'b0;
    req = 3'b000;
    addr = '0;
    repeat (2) @(posedge clk);
    fix = 1'b1;
    addr[31:16] = 16'h0123;
    cyc(3'b010, 1'b0, 1'b0);
    idle(6);
    fix = 1'b0;
    cyc(3'b000, 1'b0, 1'b1);
    repeat (6) cyc(3'b111, 1'b0, 1'b0);
    idle(6);
    cyc(3'b000, 1'b0, 1'b1);
    repeat (4) cyc(3'b111, 1'b1, 1'b0);
    repeat (2) cyc(3'b110, 1'b1, 1'b0);
    idle(4);
    repeat (3) cyc(3'b110, 1'b1, 1'b0);
    repeat (3) cyc(3'b110, 1'b0, 1'b0);
    idle(6);
    cyc(3'b100, 1'b0, 1'b0);
    cyc(3'b000, 1'b0, 1'b1);
    idle(4);
    cyc(3'b111, 1'b0, 1'b0);
    idle(6);
    cyc(3'b010, 1'b0, 1'b0);
    cyc(3'b100, 1'b0, 1'b0);
    cyc(3'b010, 1'b0, 1'b0);
    idle(8);
    d = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 3; i++)
        r[i] = (last_req[i] && !last_gnt[i]) ? 1'b1 : ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) d = ~d;
      cyc(r, d, $urandom_range(0, 99) == 0);
    end
    idle(8);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
